// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - Receive buffer: captures bytes from the MiniUart receive unit into a FWFT FIFO
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   rx_data       byte from receive unit, stable while rx_av is high
//   rx_av         byte-available level from receive unit (foreign clock domain)
//   rx_ack        one-clock read-over pulse back to the receive unit
//   rd_en         CPU pop request, one entry per cycle
//   rd_data       FIFO head (first-word-fall-through), 8'h00 when empty
//   empty, full   FIFO occupancy flags
//   count         entries held, 0..DEPTH
//   overrun       sticky flag: a byte was dropped because the FIFO was full
//   overrun_clr   clears overrun (a same-cycle drop wins)
//   irq           (count >= THRESH) | overrun

module uart_rx_fifo #(
    parameter int AW     = 4,
    parameter int THRESH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_av,
    output logic          rx_ack,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic          irq
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_WCLR = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_av_m;
    logic          r_av_s;
    logic          r_rx_ack;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    logic          w_capt;
    logic          w_pop;
    logic          w_space;
    logic          w_push;
    logic          w_drop;

    // rx_av is launched from a flop on a derived clock; only av_s is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_av_m <= 1'b0;
            r_av_s <= 1'b0;
        end else begin
            r_av_m <= rx_av;
            r_av_s <= r_av_m;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. WCLR holds until the receive unit has dropped rx_av,
    // so a byte can never be captured twice.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (r_av_s) w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_WCLR;
            S_WCLR:  if (!r_av_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. A pop in the capture cycle frees the slot being written.
    always_comb begin
        w_capt  = (r_state == S_CAPT);
        w_pop   = rd_en && !empty;
        w_space = !full || w_pop;
        w_push  = w_capt && w_space;
        w_drop  = w_capt && !w_space;
    end

    // rx_ack is registered so it is high exactly for the CAPT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ack <= 1'b0;
        end else begin
            r_rx_ack <= (w_state_nxt == S_CAPT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_ack  = r_rx_ack;
    assign count   = r_count;
    assign empty   = (r_count == '0);
    assign full    = (r_count == DEPTH_C);
    assign overrun = r_overrun;
    assign rd_data = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign irq     = (r_count >= THRESH_C) || r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Self-checking bench for uart_rx_fifo against a queue-based reference model

module tb_uart_rx_fifo;

    localparam int AW     = 4;
    localparam int THRESH = 1;
    localparam int DEPTH  = 1 << AW;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_av;
    logic          rx_ack;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          overrun_clr;
    logic          irq;

    uart_rx_fifo #(
        .AW     (AW),
        .THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_av       (rx_av),
        .rx_ack      (rx_ack),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;

    logic [7:0] mq[$];
    logic       ov;
    logic       xfer_active;
    int         xfer_age;
    int         drop_age;
    logic [7:0] xfer_data;
    logic       auto_drop;
    logic [7:0] last_out;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic exp_ack);
        int         n;
        logic [7:0] head;
        n    = mq.size();
        head = (n != 0) ? mq[0] : 8'h00;
        chk("rx_ack",  32'(rx_ack),  32'(exp_ack));
        chk("count",   32'(count),   32'(n));
        chk("empty",   32'(empty),   32'(n == 0));
        chk("full",    32'(full),    32'(n == DEPTH));
        chk("rd_data", 32'(rd_data), 32'(head));
        chk("overrun", 32'(overrun), 32'(ov));
        chk("irq",     32'(irq),     32'((n >= THRESH) || ov));
    endtask

    // The receive unit raises rx_av; capture happens on the 4th edge after,
    // with rx_ack visible after the 3rd edge.
    task automatic start_byte(input logic [7:0] d);
        rx_data     = d;
        rx_av       = 1'b1;
        xfer_data   = d;
        xfer_active = 1'b1;
        xfer_age    = 0;
        drop_age    = 1000;
    endtask

    task automatic tick(input logic rd, input logic clr);
        logic pop;
        logic push;
        logic drop;
        logic exp_ack;
        rd_en       = rd;
        overrun_clr = clr;
        @(posedge clk);
        push = 1'b0;
        drop = 1'b0;
        if (xfer_active) xfer_age++;
        pop = rd && (mq.size() != 0);
        if (xfer_active && xfer_age == 4) begin
            if (mq.size() < DEPTH || pop) push = 1'b1;
            else                          drop = 1'b1;
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(xfer_data);
        if (drop)     ov = 1'b1;
        else if (clr) ov = 1'b0;
        exp_ack = xfer_active && (xfer_age == 3);
        @(negedge clk);
        check_outputs(exp_ack);
        if (exp_ack && auto_drop) begin
            rx_av    = 1'b0;
            drop_age = 3;
        end
        if (xfer_active && !rx_av && xfer_age >= drop_age + 3) xfer_active = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic rd4, input logic clr4);
        start_byte(d);
        while (xfer_active) begin
            if (xfer_age == 3) tick(rd4, clr4);
            else               tick(1'b0, 1'b0);
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (mq.size() != 0) begin
                last_out = mq[0];
                tick(1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_av       = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
        ov          = 1'b0;
        xfer_active = 1'b0;
        xfer_age    = 0;
        drop_age    = 1000;
        xfer_data   = 8'h00;
        auto_drop   = 1'b1;
        last_out    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs(1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);

        // single byte
        send_byte(8'hA5, 1'b0, 1'b0);
        chk("single_data", 32'(rd_data), 32'h0000_00A5);
        chk("single_cnt",  32'(count),   32'd1);
        chk("single_irq",  32'(irq),     32'd1);
        tick(1'b1, 1'b0);
        chk("single_empty", 32'(empty), 32'd1);

        // fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full),  32'd1);
        chk("fill_cnt",  32'(count), 32'd16);
        send_byte(8'hFF, 1'b0, 1'b0);
        chk("ovf_flag", 32'(overrun), 32'd1);
        chk("ovf_cnt",  32'(count),   32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            tick(1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // simultaneous pop and capture while full
        tick(1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        chk("simul_cnt", 32'(count),   32'd16);
        chk("simul_ovr", 32'(overrun), 32'd0);
        drain_all();
        chk("simul_last", 32'(last_out), 32'h0000_003C);

        // clear coinciding with a drop, then a clear alone
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b1);
        chk("clr_vs_drop", 32'(overrun), 32'd1);
        tick(1'b0, 1'b1);
        chk("clr_alone", 32'(overrun), 32'd0);
        drain_all();

        // pointer wrap with interleaved pops
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            tick(1'($urandom_range(0, 1)), 1'b0);
        end
        drain_all();
        tick(1'b1, 1'b0);
        chk("underflow_cnt",  32'(count),   32'd0);
        chk("underflow_data", 32'(rd_data), 32'd0);

        // rx_av held for 10 cycles gives exactly one capture
        auto_drop = 1'b0;
        start_byte(8'h5A);
        repeat (10) tick(1'b0, 1'b0);
        chk("hold_cnt", 32'(count), 32'd1);
        rx_av    = 1'b0;
        drop_age = xfer_age;
        while (xfer_active) tick(1'b0, 1'b0);
        auto_drop = 1'b1;
        drain_all();

        // reset while in CAPT
        tick(1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        start_byte(8'h99);
        repeat (3) tick(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        mq.delete();
        ov          = 1'b0;
        xfer_active = 1'b0;
        rx_av       = 1'b0;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) tick(1'b0, 1'b0);

        // randomized traffic: a filling phase then a draining phase
        for (int c = 0; c < 600; c++) begin
            if (!xfer_active && $urandom_range(0, 2) == 0) start_byte(8'($urandom_range(0, 255)));
            if (c < 250) tick(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 15) == 0));
            else         tick(1'($urandom_range(0, 1)),       1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
